// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, buffers a word that
// arrives while the IF/ID register is stalled, and handles redirect and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifinstr,
  output logic [31:0] ifJALjump_addr,
  output logic        ifW,
  output logic        ifRST
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] ibuf, ibuf_n;
  logic [31:0] bpc, bpc_n;

  logic [31:0] pc_plus4;
  logic [31:0] bpc_plus4;
  logic        ren;
  logic        wr;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] link;

  assign pc_plus4  = pc + 32'd4;
  assign bpc_plus4 = bpc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      ibuf  <= '0;
      bpc   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ibuf  <= ibuf_n;
      bpc   <= bpc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ibuf_n  = ibuf;
    bpc_n   = bpc;
    ren     = 1'b0;
    wr      = 1'b0;
    flush   = 1'b0;
    instr   = '0;
    link    = '0;

    case (state)
      FETCH: begin
        ren   = 1'b1;
        instr = imemload;
        link  = pc_plus4;
      end
      HOLD: begin
        instr = ibuf;
        link  = bpc_plus4;
      end
      default: begin
        instr = '0;
        link  = '0;
      end
    endcase

    // halt beats redirect, which beats the normal ihit/stall handling
    if (state == HALTED) begin
      state_n = HALTED;
    end else if (halt) begin
      state_n = HALTED;
    end else if (redirect) begin
      flush   = 1'b1;
      pc_n    = {redirect_addr[31:2], 2'b00};
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            if (!stall) begin
              wr   = 1'b1;
              pc_n = pc_plus4;
            end else begin
              ibuf_n  = imemload;
              bpc_n   = pc;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            wr      = 1'b1;
            pc_n    = pc_plus4;
            state_n = FETCH;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Outputs are forced to zero combinationally while reset is held.
  assign imemaddr       = pc;
  assign iREN           = nRST & ren;
  assign ifW            = nRST & wr;
  assign ifRST          = nRST & flush;
  assign ifinstr        = nRST ? instr : '0;
  assign ifJALjump_addr = nRST ? link  : '0;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 Port: ihit  in  1  instruction memory read complete this cycle.
REQ-005 Port: imemload  in  32  instruction data, valid when ihit=1.
REQ-006 Port: stall  in  1  hazard unit: IF/ID register must hold.
REQ-007 Port: redirect  in  1  branch/jump taken; fetch must restart at redirect_addr.
REQ-008 Port: redirect_addr  in  32  target address for redirect.
REQ-009 Port: halt  in  1  stop fetching permanently until reset.
REQ-010 Port: iREN  out  1  instruction memory read enable.
REQ-011 Port: imemaddr  out  32  instruction memory address (current PC).
REQ-012 Port: ifinstr  out  32  instruction presented to IF/ID register.
REQ-013 Port: ifJALjump_addr  out  32  PC+4 of ifinstr (JAL link value).
REQ-014 Port: ifW  out  1  IF/ID write enable, one-cycle pulse per delivered instruction.
REQ-015 Port: ifRST  out  1  IF/ID flush, one-cycle pulse on redirect.

Function
REQ-016 States SHALL be FETCH, HOLD, HALTED; registers SHALL be pc[31:0], state, ibuf[31:0], bpc[31:0].
REQ-017 imemaddr SHALL equal pc in all states.
REQ-018 iREN SHALL be 1 in FETCH, 0 in HOLD and HALTED.
REQ-019 Event priority each cycle SHALL be: halt > redirect > ihit/stall logic.
REQ-020 FETCH, ihit=1, stall=0: ifinstr=imemload, ifJALjump_addr=pc+4, ifW=1; next pc=pc+4; remain FETCH.
REQ-021 FETCH, ihit=1, stall=1: ifW=0; ibuf<=imemload, bpc<=pc; next state HOLD; pc unchanged.
REQ-022 FETCH, ihit=0: ifW=0; pc and state unchanged.
REQ-023 HOLD: ifinstr=ibuf, ifJALjump_addr=bpc+4; stall=1 keeps HOLD with ifW=0; stall=0 gives ifW=1, pc<=pc+4, next FETCH.
REQ-024 redirect=1 (any non-HALTED state, stall irrelevant): ifRST=1, ifW=0, pc<={redirect_addr[31:2],2'b00}, buffered/in-flight instruction discarded, next FETCH.
REQ-025 halt=1 (any state): ifW=0, ifRST=0, next HALTED; HALTED exits only by reset.
REQ-026 ifW and ifRST SHALL never both be 1 in the same cycle.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-028 When ifW=0 and state is FETCH, ifinstr SHALL equal imemload and ifJALjump_addr pc+4 (don't-care to consumer, but deterministic).
REQ-029 Exactly one ifW pulse SHALL occur per fetched instruction; no instruction duplicated or dropped except on redirect/halt.

Reset
REQ-030 nRST=0 SHALL immediately force pc=PC_INIT, state=FETCH, ibuf=0, bpc=0.
REQ-031 While nRST=0, iREN, ifW, ifRST SHALL be 0; ifinstr and ifJALjump_addr SHALL be 0.
REQ-032 Reset mid-HOLD SHALL discard ibuf; first fetch after release SHALL be from PC_INIT.

Verification
REQ-033 Reset release, ihit=1 every cycle, imemload=addr-tagged data -> ifW=1 each cycle, imemaddr 0,4,8,...; ifJALjump_addr 4,8,12,...
REQ-034 ihit=1 with stall=1 for 3 cycles at pc=0x10 -> one HOLD entry, ifW=0 for 3 cycles, then ifinstr=buffered word, ifJALjump_addr=0x14, ifW=1 once, next imemaddr=0x14.
REQ-035 redirect=1, redirect_addr=0x103 while in HOLD -> ifRST=1, ifW=0, next imemaddr=0x100, buffered word never written.
REQ-036 halt=1 together with redirect=1 -> HALTED, iREN=0, ifRST=0; no further ifW until nRST pulse.
REQ-037 pc=0xFFFFFFFC, ihit=1 -> ifJALjump_addr=0x00000000, next imemaddr=0x00000000.
REQ-038 nRST asserted asynchronously mid-cycle in HOLD -> outputs 0 immediately; after release imemaddr=PC_INIT.
